points_display: RTL and testbench

- Score unit for the game screen: counts points on `increase` edges in a saturating BCD counter.
- Renders the score as DIGITS seven-segment digits overlaid on the VGA pixel stream.
- Sits in the VGA chain between background/sprite stages and output.
- Delays all timing signals to match the rgb pipeline.

---
 rtl/points_display.sv | 233 +++++++++++++++++++++++
 tb/tb_points_display.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/points_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// points_display : saturating BCD score counter drawn as 7-seg digits on VGA
// Revision 1.0
// ----------------------------------------------------------------------------
module points_display #(
  parameter int          DIGITS    = 3,
  parameter int          XPOS      = 300,
  parameter int          YPOS      = 100,
  parameter int          SEG_LEN   = 16,
  parameter int          SEG_W     = 4,
  parameter int          DIGIT_GAP = 8,
  parameter logic [11:0] COLOR     = 12'h055,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  module_en,
  input  logic                  increase,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   score,
  input  logic [10:0]           vcount_in,
  input  logic [10:0]           hcount_in,
  input  logic                  vsync_in,
  input  logic                  hsync_in,
  input  logic                  vblnk_in,
  input  logic                  hblnk_in,
  input  logic [11:0]           rgb_in,
  output logic [10:0]           vcount_out,
  output logic [10:0]           hcount_out,
  output logic                  vsync_out,
  output logic                  hsync_out,
  output logic                  vblnk_out,
  output logic                  hblnk_out,
  output logic [11:0]           rgb_out
);

  localparam int CELL_W = SEG_LEN + 2*SEG_W;
  localparam int CELL_H = 2*SEG_LEN + 3*SEG_W;

  localparam logic [31:0] Y0_L = 32'(YPOS);
  localparam logic [10:0] SL   = 11'(SEG_LEN);
  localparam logic [10:0] SW   = 11'(SEG_W);
  localparam logic [10:0] CW   = 11'(CELL_W);
  localparam logic [10:0] CH   = 11'(CELL_H);

  // Score path
  logic                 inc_q;
  logic                 vblnk_q;
  logic [4*DIGITS-1:0]  shown;
  logic [4*DIGITS-1:0]  score_inc;
  logic                 all_nines;
  logic                 pulse;

  assign pulse = increase & ~inc_q & module_en;

  // Ripple BCD increment; the carry surviving past the top digit means all 9s.
  always_comb begin
    score_inc = score;
    all_nines = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (all_nines) begin
        if (score[4*k +: 4] == 4'd9) begin
          score_inc[4*k +: 4] = 4'd0;
        end else begin
          score_inc[4*k +: 4] = score[4*k +: 4] + 4'd1;
          all_nines           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q   <= 1'b0;
      vblnk_q <= 1'b0;
      shown   <= '0;
      score   <= '0;
    end else begin
      inc_q   <= increase;
      vblnk_q <= vblnk_in;
      if (vblnk_in && !vblnk_q) begin
        shown <= score;
      end
      if (clear) begin
        score <= '0;
      end else if (pulse && !all_nines) begin
        score <= score_inc;
      end
    end
  end

  // Stage 1 geometry
  logic [DIGITS-1:0]        hit_w;
  logic [DIGITS-1:0][10:0]  rx_w;
  logic [DIGITS-1:0]        blank_w;
  logic                     v_in_band;
  logic [10:0]              ry_w;
  logic                     zero_run;

  assign v_in_band = (32'(vcount_in) >= Y0_L) && (32'(vcount_in) < Y0_L + 32'(CELL_H));
  assign ry_w      = vcount_in - Y0_L[10:0];

  for (genvar k = 0; k < DIGITS; k++) begin : g_cell
    localparam int          X0   = XPOS + (DIGITS-1-k)*(CELL_W+DIGIT_GAP);
    localparam logic [31:0] X0_L = 32'(X0);
    assign hit_w[k] = (32'(hcount_in) >= X0_L) && (32'(hcount_in) < X0_L + 32'(CELL_W))
                      && v_in_band;
    assign rx_w[k]  = hcount_in - X0_L[10:0];
  end

  // A digit is blank while it and everything to its left is zero; digit 0 never blanks.
  always_comb begin
    blank_w  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS-1; k >= 1; k--) begin
      zero_run   = zero_run & (shown[4*k +: 4] == 4'd0);
      blank_w[k] = LZ_BLANK & zero_run;
    end
  end

  logic [DIGITS-1:0]        hit_s1;
  logic [DIGITS-1:0][10:0]  rx_s1;
  logic [10:0]              ry_s1;
  logic [DIGITS-1:0]        blank_s1;
  logic [4*DIGITS-1:0]      digit_s1;
  logic                     en_s1;
  logic [10:0]              hcount_s1;
  logic [10:0]              vcount_s1;
  logic                     hsync_s1;
  logic                     vsync_s1;
  logic                     hblnk_s1;
  logic                     vblnk_s1;
  logic [11:0]              rgb_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_s1    <= '0;
      rx_s1     <= '0;
      ry_s1     <= '0;
      blank_s1  <= '0;
      digit_s1  <= '0;
      en_s1     <= 1'b0;
      hcount_s1 <= '0;
      vcount_s1 <= '0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      hblnk_s1  <= 1'b0;
      vblnk_s1  <= 1'b0;
      rgb_s1    <= '0;
    end else begin
      hit_s1    <= hit_w;
      rx_s1     <= rx_w;
      ry_s1     <= ry_w;
      blank_s1  <= blank_w;
      digit_s1  <= shown;
      en_s1     <= module_en;
      hcount_s1 <= hcount_in;
      vcount_s1 <= vcount_in;
      hsync_s1  <= hsync_in;
      vsync_s1  <= vsync_in;
      hblnk_s1  <= hblnk_in;
      vblnk_s1  <= vblnk_in;
      rgb_s1    <= rgb_in;
    end
  end

  // Segment bit order: bit0 = a ... bit6 = g
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] seg_region(input logic [10:0] rx, input logic [10:0] ry);
    logic mid_x, left_x, right_x, top_y, low_y;
    mid_x   = (rx >= SW) && (rx < SW + SL);
    left_x  = (rx < SW);
    right_x = (rx >= SW + SL) && (rx < CW);
    top_y   = (ry >= SW) && (ry < SW + SL);
    low_y   = (ry >= SW + SW + SL) && (ry < SW + SW + SL + SL);
    seg_region[0] = (ry < SW) && mid_x;
    seg_region[1] = right_x && top_y;
    seg_region[2] = right_x && low_y;
    seg_region[3] = (ry >= SW + SW + SL + SL) && (ry < CH) && mid_x;
    seg_region[4] = left_x && low_y;
    seg_region[5] = left_x && top_y;
    seg_region[6] = (ry >= SW + SL) && (ry < SW + SW + SL) && mid_x;
  endfunction

  // Stage 2: decode and colour mux
  logic [DIGITS-1:0] lit;
  logic              draw;

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    assign lit[k] = hit_s1[k] & ~blank_s1[k]
                    & (|(seg_decode(digit_s1[4*k +: 4]) & seg_region(rx_s1[k], ry_s1)));
  end

  assign draw = (|lit) & en_s1 & ~hblnk_s1 & ~vblnk_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      vsync_out  <= vsync_s1;
      hblnk_out  <= hblnk_s1;
      vblnk_out  <= vblnk_s1;
      rgb_out    <= draw ? COLOR : rgb_s1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_points_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_points_display : randomized bench with integer score / pixel reference model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_points_display;

  localparam int          DIGITS = 3;
  localparam int          XPOS   = 300;
  localparam int          YPOS   = 100;
  localparam int          L      = 16;
  localparam int          W      = 4;
  localparam int          GAP    = 8;
  localparam logic [11:0] COLOR  = 12'h055;
  localparam int          CW     = L + 2*W;
  localparam int          CH     = 2*L + 3*W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          clk_run = 1'b1;
  logic        module_en = 1'b0;
  logic        increase = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] score;
  logic [10:0] vcount_in = '0;
  logic [10:0] hcount_in = '0;
  logic        vsync_in = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic        hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] vcount_out;
  logic [10:0] hcount_out;
  logic        vsync_out;
  logic        hsync_out;
  logic        vblnk_out;
  logic        hblnk_out;
  logic [11:0] rgb_out;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  points_display dut (
    .clk        (clk),
    .rst        (rst),
    .module_en  (module_en),
    .increase   (increase),
    .clear      (clear),
    .score      (score),
    .vcount_in  (vcount_in),
    .hcount_in  (hcount_in),
    .vsync_in   (vsync_in),
    .hsync_in   (hsync_in),
    .vblnk_in   (vblnk_in),
    .hblnk_in   (hblnk_in),
    .rgb_in     (rgb_in),
    .vcount_out (vcount_out),
    .hcount_out (hcount_out),
    .vsync_out  (vsync_out),
    .hsync_out  (hsync_out),
    .vblnk_out  (vblnk_out),
    .hblnk_out  (hblnk_out),
    .rgb_out    (rgb_out)
  );

  always #5 if (clk_run) clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } vid_t;

  function automatic bit has_seg(input int d, input string c);
    string s;
    case (d)
      0: s = "abcdef";
      1: s = "bc";
      2: s = "abdeg";
      3: s = "abcdg";
      4: s = "bcfg";
      5: s = "acdfg";
      6: s = "acdefg";
      7: s = "abc";
      8: s = "abcdefg";
      default: s = "abcdfg";
    endcase
    for (int i = 0; i < s.len(); i++) if (s[i] == c[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [11:0] exp_rgb(input int h, input int v, input logic [11:0] rgb,
                                          input bit en, input bit hb, input bit vb, input int shown);
    int p10 = 1;
    if (!en || hb || vb) return rgb;
    for (int k = 0; k < DIGITS; k++) begin
      int x0, rx, ry, dig;
      bit blank;
      x0    = XPOS + (DIGITS-1-k)*(CW+GAP);
      rx    = h - x0;
      ry    = v - YPOS;
      dig   = (shown / p10) % 10;
      blank = (k > 0) && (shown < p10);
      if (!blank && rx >= 0 && rx < CW && ry >= 0 && ry < CH) begin
        if (ry < W && rx >= W && rx < W+L && has_seg(dig, "a")) return COLOR;
        if (rx >= W+L && ry >= W && ry < W+L && has_seg(dig, "b")) return COLOR;
        if (rx >= W+L && ry >= 2*W+L && ry < 2*W+2*L && has_seg(dig, "c")) return COLOR;
        if (ry >= 2*W+2*L && rx >= W && rx < W+L && has_seg(dig, "d")) return COLOR;
        if (rx < W && ry >= 2*W+L && ry < 2*W+2*L && has_seg(dig, "e")) return COLOR;
        if (rx < W && ry >= W && ry < W+L && has_seg(dig, "f")) return COLOR;
        if (ry >= W+L && ry < 2*W+L && rx >= W && rx < W+L && has_seg(dig, "g")) return COLOR;
      end
      p10 = p10 * 10;
    end
    return rgb;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic vid_t mk_vid(input int shown);
    vid_t r;
    r.h   = hcount_in;
    r.v   = vcount_in;
    r.hs  = hsync_in;
    r.vs  = vsync_in;
    r.hb  = hblnk_in;
    r.vb  = vblnk_in;
    r.rgb = exp_rgb(int'(hcount_in), int'(vcount_in), rgb_in, module_en, hblnk_in, vblnk_in, shown);
    return r;
  endfunction

  vid_t m_d1, m_d2;
  int   m_score, m_shown;
  bit   m_inc_q, m_vb_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1    <= '0;
      m_d2    <= '0;
      m_score <= 0;
      m_shown <= 0;
      m_inc_q <= 1'b0;
      m_vb_q  <= 1'b0;
    end else begin
      m_d1    <= mk_vid(m_shown);
      m_d2    <= m_d1;
      if (vblnk_in && !m_vb_q) m_shown <= m_score;
      m_vb_q  <= vblnk_in;
      if (clear) m_score <= 0;
      else if (increase && !m_inc_q && module_en && m_score < 999) m_score <= m_score + 1;
      m_inc_q <= increase;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && cmp_en) begin
      chk("rgb_out", rgb_out, m_d2.rgb);
      chk("hcount_out", hcount_out, m_d2.h);
      chk("vcount_out", vcount_out, m_d2.v);
      chk("timing_out", {hsync_out, vsync_out, hblnk_out, vblnk_out},
          {m_d2.hs, m_d2.vs, m_d2.hb, m_d2.vb});
      chk("score", score, to_bcd(m_score));
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse();
    @(negedge clk); increase = 1'b1;
    @(negedge clk); increase = 1'b0;
  endtask

  task automatic pix_check(input string name, input int h, input int v,
                           input logic [11:0] rgb, input logic [11:0] exp);
    @(negedge clk);
    hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = rgb;
    hblnk_in = 1'b0; vblnk_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (2) @(negedge clk);
    chk(name, rgb_out, exp);
  endtask

  // mode 0: hold increase, 1: single pulse at line 120, 2: random increase/clear
  task automatic run_lines(input int vs, input int ve, input int mode);
    for (int v = vs; v <= ve; v++) begin
      for (int h = 296; h <= 403; h++) begin
        @(negedge clk);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = (h >= 396);
        vblnk_in  = (v >= 150);
        hsync_in  = (h >= 398 && h < 401);
        vsync_in  = (v == 151);
        rgb_in    = 12'($urandom);
        clear     = 1'b0;
        if (mode == 1) begin
          increase = (v == 120 && h == 296);
        end else if (mode == 2) begin
          if ($urandom_range(0, 7) == 0) increase = ~increase;
          clear = ($urandom_range(0, 3999) == 0);
        end
      end
    end
    @(negedge clk);
    increase = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_score", score, 12'h000);
    chk("reset_rgb", rgb_out, 12'h000);
    chk("reset_hcount", hcount_out, 11'd0);
    chk("reset_timing", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 4'b0000);
    rst       = 1'b0;
    cmp_en    = 1'b1;
    module_en = 1'b1;

    pix_check("seg_a_lit", 370, 101, 12'h3A1, 12'h055);
    pix_check("lz_blank", 306, 101, 12'h3A2, 12'h3A2);
    pix_check("corner", 364, 100, 12'h3A3, 12'h3A3);

    repeat (5) pulse();
    @(negedge clk); increase = 1'b1;
    repeat (20) @(negedge clk);
    increase = 1'b0;
    @(negedge clk);
    chk("score_6", score, 12'h006);

    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    repeat (99) pulse();
    chk("score_099", score, 12'h099);
    @(negedge clk); increase = 1'b1;
    @(negedge clk); increase = 1'b0;
    chk("score_carry_100", score, 12'h100);

    repeat (899) pulse();
    chk("score_999", score, 12'h999);
    repeat (3) pulse();
    chk("score_saturate", score, 12'h999);
    pix_check("digits_999", 370, 101, 12'h111, 12'h055);

    @(negedge clk); clear = 1'b1; increase = 1'b1;
    @(negedge clk); clear = 1'b0; increase = 1'b0;
    chk("clear_priority", score, 12'h000);

    repeat (2) pulse();
    module_en = 1'b0;
    repeat (3) pulse();
    chk("disabled_ignored", score, 12'h002);
    @(negedge clk); increase = 1'b1;
    repeat (2) @(negedge clk);
    module_en = 1'b1;
    repeat (3) @(negedge clk);
    increase = 1'b0;
    @(negedge clk);
    chk("held_across_enable", score, 12'h002);
    module_en = 1'b0;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_while_disabled", score, 12'h000);
    module_en = 1'b1;

    // anti-tearing: shown score latched only at vblank rise
    @(negedge clk); vblnk_in = 1'b1;
    @(negedge clk); vblnk_in = 1'b0;
    run_lines(96, 149, 1);
    chk("tear_score_1", score, 12'h001);
    pix_check("tear_hold", 365, 130, 12'h5A5, 12'h055);
    run_lines(150, 153, 0);
    pix_check("tear_update", 365, 130, 12'h5A6, 12'h5A6);

    repeat (2) run_lines(96, 153, 2);
    module_en = 1'b0;
    run_lines(96, 153, 2);
    module_en = 1'b1;
    run_lines(96, 153, 2);

    // asynchronous reset with the clock stopped
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    pulse();
    module_en = 1'b0;
    pix_check("passthru_pre_reset", 10, 10, 12'hABC, 12'hABC);
    chk("score_pre_reset", score, 12'h001);
    clk_run = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_score", score, 12'h000);
    chk("async_rst_rgb", rgb_out, 12'h000);
    chk("async_rst_counts", {hcount_out, vcount_out}, 22'd0);
    chk("async_rst_timing", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 4'b0000);
    #3 rst = 1'b0;
    #1 clk_run = 1'b1;
    module_en = 1'b1;
    pulse();
    @(negedge clk);
    chk("count_after_reset", score, 12'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
